// File: rtl/result_tx_framer.sv
// ============================================================================
// Module: result_tx_framer
//
// Purpose
//   Return path of the UART link. Once argmax has finished, this block frames
//   the predicted class and the complete logit vector as a byte stream and
//   feeds it to uart_tx one byte at a time through the tx_dv / tx_busy
//   handshake. The predicted index and the logits are snapshotted when start
//   is accepted, so the dense stage may begin the next frame while this one
//   is still being transmitted.
//
//   Frame layout:
//     SYNC_BYTE, {zero pad, idx}, logit[0] .. logit[NUM_CLASSES-1], [checksum]
//   Each logit is sign-extended to a whole number of bytes (BPW bytes) and is
//   sent most-significant byte first.
//
// Ports
//   clk          in   1                       system clock
//   reset_n      in   1                       asynchronous active-low reset
//   start        in   1                       1-cycle pulse: latch inputs, begin frame
//   idx          in   IDXW                    predicted class
//   logits_flat  in   DATA_WIDTH*NUM_CLASSES  logit k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tx_busy      in   1                       from uart_tx: byte in flight
//   tx_dv        out  1                       to uart_tx: 1-cycle byte-valid strobe
//   tx_byte      out  8                       to uart_tx: byte, valid while tx_dv=1
//   busy         out  1                       high from accepted start until done
//   done         out  1                       1-cycle pulse after the last byte leaves
//
// Configuration
//   RESULT_TX_CHECKSUM_EN  when defined, one trailing byte is appended holding
//                          the mod-256 sum of every byte after SYNC_BYTE.
//                          When undefined, no checksum logic is built.
// ============================================================================
module result_tx_framer #(
    parameter int         DATA_WIDTH  = 16,
    parameter int         NUM_CLASSES = 10,
    parameter int         IDXW        = 4,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [IDXW-1:0]                   idx,
    input  logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_flat,
    input  logic                              tx_busy,
    output logic                              tx_dv,
    output logic [7:0]                        tx_byte,
    output logic                              busy,
    output logic                              done
);

    // Bytes needed to carry one logit, and the resulting frame geometry.
    localparam int BPW      = (DATA_WIDTH + 7) / 8;
    localparam int BASE_LEN = 2 + NUM_CLASSES * BPW;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int FRAME_LEN = BASE_LEN + 1;
`else
    localparam int FRAME_LEN = BASE_LEN;
`endif
    // Sized with headroom so the post-increment on the final byte never wraps.
    localparam int             CNTW     = $clog2(BASE_LEN + 2);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_FIN
    } state_t;

    state_t                            state;
    state_t                            state_next;
    logic [CNTW-1:0]                   byte_cnt;
    logic                              ack_cnt;
    logic [IDXW-1:0]                   idx_q;
    logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_q;
    logic [7:0]                        sel_byte;
    logic signed [DATA_WIDTH-1:0]      logit_word;
    logic signed [8*BPW-1:0]           ext_word;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]                        csum;
`endif

    // State register. An asserted reset drops straight back to IDLE, which
    // also removes tx_dv and busy in the same instant because both are
    // decoded from the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    // LOAD only advances once the UART is idle, which is what guarantees a
    // strobe is never raised on top of a byte still in flight. WAIT_ACK gives
    // the UART two cycles to raise tx_busy; a UART fast enough to finish
    // inside that window is treated as having accepted the byte.
    always_comb begin
        state_next = state;
        tx_dv      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (!tx_busy) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                busy       = 1'b1;
                tx_dv      = 1'b1;
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                busy = 1'b1;
                if (tx_busy || ack_cnt) begin
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                busy = 1'b1;
                if (!tx_busy) begin
                    state_next = (byte_cnt == LAST_CNT) ? ST_FIN : ST_LOAD;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Byte selector: maps the current byte position onto the snapshot.
    // Positions 2.. walk through the logits, BPW bytes each, high byte first.
    // The header, index and checksum positions override the logit decode.
    always_comb begin
        sel_byte   = 8'h00;
        logit_word = '0;
        ext_word   = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            logit_word = logits_q[k*DATA_WIDTH +: DATA_WIDTH];
            ext_word   = (8*BPW)'(logit_word);
            for (int b = 0; b < BPW; b++) begin
                if (byte_cnt == CNTW'(2 + k*BPW + b)) begin
                    sel_byte = ext_word[(BPW-1-b)*8 +: 8];
                end
            end
        end
        if (byte_cnt == CNTW'(0)) begin
            sel_byte = SYNC_BYTE;
        end
        if (byte_cnt == CNTW'(1)) begin
            sel_byte = 8'(idx_q);
        end
`ifdef RESULT_TX_CHECKSUM_EN
        if (byte_cnt == CNTW'(BASE_LEN)) begin
            sel_byte = csum;
        end
`endif
    end

    // Datapath registers.
    // The snapshot is taken only when a start is accepted in IDLE, so a start
    // arriving mid-frame (or during FIN) cannot disturb what is being sent.
    // tx_byte is written only in LOAD, which keeps it stable through the
    // strobe and the whole UART handshake that follows. The byte counter
    // advances once the UART has let go of the current byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            ack_cnt  <= 1'b0;
            idx_q    <= '0;
            logits_q <= '0;
            tx_byte  <= 8'h00;
`ifdef RESULT_TX_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx_q    <= idx;
                        logits_q <= logits_flat;
                        byte_cnt <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
                        csum     <= 8'h00;
`endif
                    end
                end
                ST_LOAD: begin
                    tx_byte <= sel_byte;
                end
                ST_SEND: begin
                    ack_cnt <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
                    // Sum every issued byte between the header and the
                    // checksum itself.
                    if ((byte_cnt != CNTW'(0)) && (byte_cnt < CNTW'(BASE_LEN))) begin
                        csum <= csum + tx_byte;
                    end
`endif
                end
                ST_WAIT_ACK: begin
                    ack_cnt <= 1'b1;
                end
                ST_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        byte_cnt <= byte_cnt + CNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
